// File: rtl/router_fsm_nport_pkg.sv
// Shared definitions for the N-port router control FSM: state encodings and a
// constant clog2 helper used to size the payload beat counter.
package router_fsm_nport_pkg;

  localparam logic [3:0] ST_DECODE_ADDRESS     = 4'd0;
  localparam logic [3:0] ST_LOAD_FIRST_DATA    = 4'd1;
  localparam logic [3:0] ST_LOAD_DATA          = 4'd2;
  localparam logic [3:0] ST_WAIT_TILL_EMPTY    = 4'd3;
  localparam logic [3:0] ST_FIFO_FULL_STATE    = 4'd4;
  localparam logic [3:0] ST_LOAD_AFTER_FULL    = 4'd5;
  localparam logic [3:0] ST_LOAD_PARITY        = 4'd6;
  localparam logic [3:0] ST_CHECK_PARITY_ERROR = 4'd7;
  localparam logic [3:0] ST_DROP_PACKET        = 4'd8;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = ST_DECODE_ADDRESS,
    LOAD_FIRST_DATA    = ST_LOAD_FIRST_DATA,
    LOAD_DATA          = ST_LOAD_DATA,
    WAIT_TILL_EMPTY    = ST_WAIT_TILL_EMPTY,
    FIFO_FULL_STATE    = ST_FIFO_FULL_STATE,
    LOAD_AFTER_FULL    = ST_LOAD_AFTER_FULL,
    LOAD_PARITY        = ST_LOAD_PARITY,
    CHECK_PARITY_ERROR = ST_CHECK_PARITY_ERROR,
    DROP_PACKET        = ST_DROP_PACKET
  } state_e;

  // Width needed to hold values 0..value-1; never less than 1 bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/router_fsm_nport_if.sv
// Control bus between the router FSM, the register block and the output FIFOs.
// slave = FSM side, master = surrounding datapath/FIFO side.
interface router_fsm_nport_if #(
  parameter int N_PORTS = 3,
  parameter int ADDR_W  = 2
);

  logic               pkt_valid;
  logic [ADDR_W-1:0]  data_in;
  logic               fifo_full;
  logic [N_PORTS-1:0] fifo_empty;
  logic [N_PORTS-1:0] soft_reset;
  logic               parity_done;
  logic               low_packet_valid;

  logic               write_enb_reg;
  logic               detect_add;
  logic               ld_state;
  logic               laf_state;
  logic               lfd_state;
  logic               full_state;
  logic               rst_int_reg;
  logic               busy;
  logic [ADDR_W-1:0]  dest_sel;
  logic               addr_err;
  logic               len_err;

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_packet_valid,
    output write_enb_reg, detect_add, ld_state, laf_state, lfd_state,
           full_state, rst_int_reg, busy, dest_sel, addr_err, len_err
  );

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_packet_valid,
    input  write_enb_reg, detect_add, ld_state, laf_state, lfd_state,
           full_state, rst_int_reg, busy, dest_sel, addr_err, len_err
  );

endinterface

// File: rtl/router_fsm_nport_len_counter.sv
// Saturating payload beat counter (module router_len_counter); only instantiated
// when the overlength limit ROUTER_FSM_MAXLEN_EN is enabled.
module router_len_counter
  import router_fsm_nport_pkg::*;
#(
  parameter int MAX_LEN = 64,
  localparam int CNT_W  = clog2(MAX_LEN + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_W'(MAX_LEN))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/router_fsm_nport.sv
// N-port router control FSM: address decode, FIFO-status gated writes, parity
// sequencing, invalid-address drop and soft-reset abort. Optional: ROUTER_FSM_MAXLEN_EN.
module router_fsm_nport
  import router_fsm_nport_pkg::*;
#(
  parameter int N_PORTS = 3,
  parameter int ADDR_W  = 2,
  parameter int MAX_LEN = 64
) (
  input  logic              clock,
  input  logic              resetn,
  router_fsm_nport_if.slave bus
);

  localparam int CNT_W = clog2(MAX_LEN + 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_dest_sel;
  logic              r_write_enb;
  logic              r_detect_add;
  logic              r_ld;
  logic              r_laf;
  logic              r_lfd;
  logic              r_full;
  logic              r_rst_int;
  logic              r_busy;
  logic              r_addr_err;

  state_e            w_next;
  logic              w_addr_ok;
  logic              w_empty_in;
  logic              w_empty_sel;
  logic              w_soft_sel;
  logic              w_len_over;
  logic [CNT_W-1:0]  w_cnt;

  // Range-safe pick of a per-port flag; out-of-range indices read as 0.
  function automatic logic port_bit(input logic [N_PORTS-1:0] vec,
                                    input logic [ADDR_W-1:0]  idx);
    logic b;
    b = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (idx == ADDR_W'(p)) b = vec[p];
    end
    return b;
  endfunction

  assign w_addr_ok   = ({1'b0, bus.data_in} < (ADDR_W + 1)'(N_PORTS));
  assign w_empty_in  = port_bit(bus.fifo_empty, bus.data_in);
  assign w_empty_sel = port_bit(bus.fifo_empty, r_dest_sel);
  assign w_soft_sel  = port_bit(bus.soft_reset, r_dest_sel);

`ifdef ROUTER_FSM_MAXLEN_EN
  logic r_len_err;

  router_len_counter #(.MAX_LEN(MAX_LEN)) u_len_cnt (
    .clock  (clock),
    .resetn (resetn),
    .i_clr  (r_state == DECODE_ADDRESS),
    .i_inc  (r_state == LOAD_DATA),
    .o_cnt  (w_cnt)
  );

  assign bus.len_err = r_len_err;
`else
  // Without the length limit the beat count reads as zero, so the overlength
  // compare below can never fire and packets are unbounded.
  assign w_cnt       = '0;
  assign bus.len_err = 1'b0;
`endif

  assign w_len_over = bus.pkt_valid && (w_cnt == CNT_W'(MAX_LEN));

  always_comb begin
    w_next = r_state;
    if (w_soft_sel && (r_state != DECODE_ADDRESS) && (r_state != DROP_PACKET)) begin
      w_next = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS: begin
          if (bus.pkt_valid) begin
            if (!w_addr_ok)     w_next = DROP_PACKET;
            else if (w_empty_in) w_next = LOAD_FIRST_DATA;
            else                 w_next = WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY:    if (w_empty_sel) w_next = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:    w_next = LOAD_DATA;
        LOAD_DATA: begin
          if (bus.fifo_full)       w_next = FIFO_FULL_STATE;
          else if (w_len_over)     w_next = DROP_PACKET;
          else if (!bus.pkt_valid) w_next = LOAD_PARITY;
        end
        FIFO_FULL_STATE:    if (!bus.fifo_full) w_next = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (bus.parity_done)           w_next = DECODE_ADDRESS;
          else if (bus.low_packet_valid) w_next = LOAD_PARITY;
          else                           w_next = LOAD_DATA;
        end
        LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: w_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        DROP_PACKET:        if (!bus.pkt_valid) w_next = DECODE_ADDRESS;
        default:            w_next = DECODE_ADDRESS;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= DECODE_ADDRESS;
      r_dest_sel   <= '0;
      r_write_enb  <= 1'b0;
      r_detect_add <= 1'b1;
      r_ld         <= 1'b0;
      r_laf        <= 1'b0;
      r_lfd        <= 1'b0;
      r_full       <= 1'b0;
      r_rst_int    <= 1'b0;
      r_busy       <= 1'b0;
      r_addr_err   <= 1'b0;
`ifdef ROUTER_FSM_MAXLEN_EN
      r_len_err    <= 1'b0;
`endif
    end else begin
      r_state      <= w_next;
      if ((r_state == DECODE_ADDRESS) && bus.pkt_valid) r_dest_sel <= bus.data_in;
      r_write_enb  <= (w_next == LOAD_DATA) || (w_next == LOAD_PARITY) ||
                      (w_next == LOAD_AFTER_FULL);
      r_detect_add <= (w_next == DECODE_ADDRESS);
      r_ld         <= (w_next == LOAD_DATA);
      r_laf        <= (w_next == LOAD_AFTER_FULL);
      r_lfd        <= (w_next == LOAD_FIRST_DATA);
      r_full       <= (w_next == FIFO_FULL_STATE);
      r_rst_int    <= (w_next == CHECK_PARITY_ERROR);
      r_busy       <= !(w_next inside {DECODE_ADDRESS, LOAD_DATA, DROP_PACKET});
      r_addr_err   <= (r_state == DECODE_ADDRESS) && bus.pkt_valid && !w_addr_ok;
`ifdef ROUTER_FSM_MAXLEN_EN
      r_len_err    <= (r_state == LOAD_DATA) && (w_next == DROP_PACKET);
`endif
    end
  end

  assign bus.write_enb_reg = r_write_enb;
  assign bus.detect_add    = r_detect_add;
  assign bus.ld_state      = r_ld;
  assign bus.laf_state     = r_laf;
  assign bus.lfd_state     = r_lfd;
  assign bus.full_state    = r_full;
  assign bus.rst_int_reg   = r_rst_int;
  assign bus.busy          = r_busy;
  assign bus.dest_sel      = r_dest_sel;
  assign bus.addr_err      = r_addr_err;

endmodule
